// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared types and constants for the key debouncer
package key_debounce_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } ch_state_e;

  // Default number of consecutive 1 kHz ticks a level must hold
  localparam int DEBOUNCE_MS_DEFAULT = 20;

endpackage

// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - one button channel: raw level in, press pulse and held level out
interface key_debounce_if;

  logic raw;
  logic pulse;
  logic lvl;

  // Drives the raw button, observes the debounced results
  modport master (output raw, input pulse, input lvl);

  // Debounce channel side
  modport slave (input raw, output pulse, output lvl);

endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one button: synchronizer, debounce FSM, counter, pulse and level registers
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic         clk_1kHz,
  input  logic         rst_n,
  key_debounce_if.slave btn
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             lvl_q, lvl_d;

  // Two-flop synchronizer; only the second stage is used by the FSM
  always_comb begin
    sync1_d = btn.raw;
    sync2_d = sync1_q;
  end

  // Next state, counter, press pulse and held level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Level follows the state being entered so lvl_q tracks state_q exactly
    lvl_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      lvl_q   <= lvl_d;
    end
  end

  assign btn.pulse = pulse_q;
  assign btn.lvl   = lvl_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four independent debounced push-button channels
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic clk_1kHz,
  input  logic rst_n,
  input  logic btn_7,
  input  logic btn_6,
  input  logic btn_5,
  input  logic btn_4,
  output logic btn_7_out,
  output logic btn_6_out,
  output logic btn_5_out,
  output logic btn_4_out,
  output logic btn_7_lvl,
  output logic btn_6_lvl,
  output logic btn_5_lvl,
  output logic btn_4_lvl
);

  logic [3:0] raw_w;
  logic [3:0] pulse_w;
  logic [3:0] lvl_w;

  assign raw_w = {btn_7, btn_6, btn_5, btn_4};

  // Identical channels with no interaction between them
  for (genvar i = 0; i < 4; i++) begin : g_ch
    key_debounce_if ch_if ();

    assign ch_if.raw = raw_w[i];

    key_debounce_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_ch (
      .clk_1kHz(clk_1kHz),
      .rst_n   (rst_n),
      .btn     (ch_if.slave)
    );

    assign pulse_w[i] = ch_if.pulse;
    assign lvl_w[i]   = ch_if.lvl;
  end

  assign {btn_7_out, btn_6_out, btn_5_out, btn_4_out} = pulse_w;
  assign {btn_7_lvl, btn_6_lvl, btn_5_lvl, btn_4_lvl} = lvl_w;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
module tb_key_debounce;

  localparam int DEB = 4;

  logic clk_1kHz;
  logic rst_n;

  key_debounce_if i7 ();
  key_debounce_if i6 ();
  key_debounce_if i5 ();
  key_debounce_if i4 ();

  wire [3:0] outs = {i7.pulse, i6.pulse, i5.pulse, i4.pulse};
  wire [3:0] lvls = {i7.lvl, i6.lvl, i5.lvl, i4.lvl};

  int vec;
  int errs;
  int pcnt [4];
  logic [3:0] prev_outs;
  logic [3:0] dbl;

  key_debounce #(.DEBOUNCE_MS(DEB)) dut (
    .clk_1kHz (clk_1kHz),
    .rst_n    (rst_n),
    .btn_7    (i7.raw),
    .btn_6    (i6.raw),
    .btn_5    (i5.raw),
    .btn_4    (i4.raw),
    .btn_7_out(i7.pulse),
    .btn_6_out(i6.pulse),
    .btn_5_out(i5.pulse),
    .btn_4_out(i4.pulse),
    .btn_7_lvl(i7.lvl),
    .btn_6_lvl(i6.lvl),
    .btn_5_lvl(i5.lvl),
    .btn_4_lvl(i4.lvl)
  );

  initial clk_1kHz = 1'b0;
  always #5 clk_1kHz = ~clk_1kHz;

  task automatic set_btn(input logic [3:0] v);
    i7.raw = v[3];
    i6.raw = v[2];
    i5.raw = v[1];
    i4.raw = v[0];
  endtask

  task automatic tick();
    @(posedge clk_1kHz);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (outs[c]) pcnt[c] = pcnt[c] + 1;
      if (outs[c] && prev_outs[c]) dbl[c] = 1'b1;
    end
    prev_outs = outs;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) pcnt[c] = 0;
    prev_outs = 4'b0;
    dbl = 4'b0;
  endtask

  task automatic do_reset();
    set_btn(4'b0000);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
  endtask

  task automatic test_reset();
    set_btn(4'b1111);
    rst_n = 1'b0;
    #1;
    vec++;
    if (outs !== 4'b0000) begin
      errs++; $display("FAIL reset_out actual=%b required=0000", outs);
    end
    vec++;
    if (lvls !== 4'b0000) begin
      errs++; $display("FAIL reset_lvl actual=%b required=0000", lvls);
    end
    for (int k = 0; k < 8; k++) tick();
    vec++;
    if (outs !== 4'b0000 || lvls !== 4'b0000) begin
      errs++; $display("FAIL reset_held actual=%b/%b required=0000/0000", outs, lvls);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    set_btn(4'b1000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      vec++;
      if (outs[3] !== (k == 6)) begin
        errs++; $display("FAIL clean_out k=%0d actual=%b required=%b", k, outs[3], (k == 6));
      end
      vec++;
      if (lvls[3] !== (k >= 6)) begin
        errs++; $display("FAIL clean_lvl k=%0d actual=%b required=%b", k, lvls[3], (k >= 6));
      end
    end
    for (int k = 0; k < 100; k++) tick();
    vec++;
    if (pcnt[3] !== 1) begin
      errs++; $display("FAIL clean_held_pulses actual=%0d required=1", pcnt[3]);
    end
    vec++;
    if (lvls[3] !== 1'b1) begin
      errs++; $display("FAIL clean_held_lvl actual=%b required=1", lvls[3]);
    end
    vec++;
    if (dbl[3] !== 1'b0) begin
      errs++; $display("FAIL clean_double_pulse actual=%b required=0", dbl[3]);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    do_reset();
    pat = 7'b1110110;
    for (int k = 1; k <= 20; k++) begin
      set_btn({1'b0, (k <= 7) ? pat[7-k] : 1'b1, 2'b00});
      tick();
      vec++;
      if (outs[2] !== (k == 13)) begin
        errs++; $display("FAIL bounce_out k=%0d actual=%b required=%b", k, outs[2], (k == 13));
      end
      vec++;
      if (lvls[2] !== (k >= 13)) begin
        errs++; $display("FAIL bounce_lvl k=%0d actual=%b required=%b", k, lvls[2], (k >= 13));
      end
    end
    vec++;
    if (pcnt[2] !== 1) begin
      errs++; $display("FAIL bounce_pulses actual=%0d required=1", pcnt[2]);
    end
  endtask

  task automatic test_release_bounce();
    do_reset();
    set_btn(4'b0010);
    for (int k = 0; k < 8; k++) tick();
    vec++;
    if (pcnt[1] !== 1 || lvls[1] !== 1'b1) begin
      errs++; $display("FAIL relb_pressed actual=%0d/%b required=1/1", pcnt[1], lvls[1]);
    end
    set_btn(4'b0000);
    tick();
    tick();
    set_btn(4'b0010);
    for (int k = 1; k <= 20; k++) begin
      tick();
      vec++;
      if (lvls[1] !== 1'b1) begin
        errs++; $display("FAIL relb_lvl k=%0d actual=%b required=1", k, lvls[1]);
      end
    end
    vec++;
    if (pcnt[1] !== 1) begin
      errs++; $display("FAIL relb_pulses actual=%0d required=1", pcnt[1]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_btn(4'b1111);
    for (int k = 1; k <= 7; k++) begin
      tick();
      vec++;
      if (outs !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
        errs++; $display("FAIL simul_out k=%0d actual=%b required=%b", k, outs,
                         ((k == 6) ? 4'b1111 : 4'b0000));
      end
    end
    vec++;
    if (lvls !== 4'b1111) begin
      errs++; $display("FAIL simul_lvl actual=%b required=1111", lvls);
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    set_btn(4'b0001);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    vec++;
    if (outs !== 4'b0000 || lvls !== 4'b0000) begin
      errs++; $display("FAIL rstmid_immediate actual=%b/%b required=0000/0000", outs, lvls);
    end
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    clear_counts();
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++;
      if (outs[0] !== (k == 6)) begin
        errs++; $display("FAIL rstmid_out k=%0d actual=%b required=%b", k, outs[0], (k == 6));
      end
    end
    vec++;
    if (pcnt[0] !== 1) begin
      errs++; $display("FAIL rstmid_pulses actual=%0d required=1", pcnt[0]);
    end
  endtask

  task automatic test_reset_pressed();
    do_reset();
    set_btn(4'b1000);
    for (int k = 0; k < 10; k++) tick();
    vec++;
    if (lvls[3] !== 1'b1) begin
      errs++; $display("FAIL rstprs_before actual=%b required=1", lvls[3]);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (lvls[3] !== 1'b0) begin
      errs++; $display("FAIL rstprs_lvl_clear actual=%b required=0", lvls[3]);
    end
    tick();
    rst_n = 1'b1;
    clear_counts();
    for (int k = 1; k <= 7; k++) begin
      tick();
      vec++;
      if (outs[3] !== (k == 6)) begin
        errs++; $display("FAIL rstprs_out k=%0d actual=%b required=%b", k, outs[3], (k == 6));
      end
    end
  endtask

  task automatic test_repeat_press();
    int t0;
    int t1;
    int np;
    do_reset();
    t0 = -1;
    t1 = -1;
    np = 0;
    for (int n = 1; n <= 30; n++) begin
      set_btn((n <= 10 || n > 20) ? 4'b0001 : 4'b0000);
      tick();
      if (outs[0]) begin
        np++;
        if (t0 < 0) t0 = n; else t1 = n;
      end
      if (n == 15 || n == 16) begin
        vec++;
        if (lvls[0] !== (n == 15)) begin
          errs++; $display("FAIL repeat_release_lvl n=%0d actual=%b required=%b", n, lvls[0], (n == 15));
        end
      end
    end
    vec++;
    if (np !== 2) begin
      errs++; $display("FAIL repeat_pulses actual=%0d required=2", np);
    end
    vec++;
    if (t0 !== 6 || t1 !== 26) begin
      errs++; $display("FAIL repeat_times actual=%0d,%0d required=6,26", t0, t1);
    end
    vec++;
    if ((t1 - t0) < 10) begin
      errs++; $display("FAIL repeat_gap actual=%0d required>=10", t1 - t0);
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst_n = 1'b0;
    set_btn(4'b0000);
    clear_counts();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_press();
    test_reset_pressed();
    test_repeat_press();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
